mdu: RTL

Multi-cycle multiply/divide unit. It sits in the execute stage beside the ALU and takes the same A/B operands and funct-code Op from decode. It owns the HI/LO registers and implements mult, multu, div, divu, mfhi, mflo, mthi and mtlo. It raises Busy so the pipeline stalls any later MDU instruction until the result is ready.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_if.sv | 16 +
 rtl/mdu_divstep.sv | 14 +
 rtl/mdu.sv | 112 +++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: widths, MIPS funct codes,
// FSM state encoding and the operand magnitude helper.
package mdu_pkg;
  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? -x : x;
  endfunction
endpackage

// File: rtl/mdu_if.sv
// Execute-stage bus between the pipeline and the multiply/divide unit.
interface mdu_if;
  import mdu_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [5:0]       Op;
  logic             Start;
  logic             Busy;
  logic [WIDTH-1:0] Out;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output A, B, Op, Start, input Busy, Out, HI, LO);
  modport slave  (input A, B, Op, Start, output Busy, Out, HI, LO);
endinterface

// File: rtl/mdu_divstep.sv
// One restoring-divide step: compare the shifted partial remainder against
// the divisor and subtract when it fits.
module mdu_divstep
  import mdu_pkg::*;
(
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remainder,
  output logic             q_bit
);
  // partial < 2*divisor, so a successful subtraction always fits in WIDTH bits
  assign q_bit     = (partial >= {1'b0, divisor});
  assign remainder = q_bit ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];
endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO: 32-step shift-add multiply,
// 32-step restoring divide, then one sign-fix cycle that commits HI/LO.
module mdu
  import mdu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  state_t             state, next_state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               neg_lo, neg_hi, div_zero, is_div_op;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic is_mul, is_div, is_signed, last_step;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem;
  logic               div_q;

  assign is_mul    = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU);
  assign is_div    = (bus.Op == OP_DIV)  || (bus.Op == OP_DIVU);
  assign is_signed = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
  assign last_step = (count == CNT_W'(ITER - 1));

  // Multiply: acc holds {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);

  // Divide: acc holds {remainder, remaining dividend bits / quotient bits}
  mdu_divstep u_divstep (
    .partial   ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
    .divisor   (operand),
    .remainder (div_rem),
    .q_bit     (div_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.Start && is_mul)      next_state = MUL;
        else if (bus.Start && is_div) next_state = DIV;
      end
      MUL:     if (last_step) next_state = FIX;
      DIV:     if (last_step) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      acc       <= '0;
      operand   <= '0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      div_zero  <= 1'b0;
      is_div_op <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start && (is_mul || is_div)) begin
            acc       <= {{WIDTH{1'b0}}, magnitude(is_mul ? bus.B : bus.A, is_signed)};
            operand   <= magnitude(is_mul ? bus.A : bus.B, is_signed);
            neg_lo    <= is_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_hi    <= is_signed && bus.A[WIDTH-1];
            div_zero  <= (bus.B == '0);
            is_div_op <= is_div;
            count     <= '0;
          end else if (bus.Start && bus.Op == OP_MTHI) begin
            hi_q <= bus.A;
          end else if (bus.Start && bus.Op == OP_MTLO) begin
            lo_q <= bus.A;
          end
        end
        MUL: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        DIV: begin
          acc   <= {div_rem, acc[WIDTH-2:0], div_q};
          count <= count + 1'b1;
        end
        FIX: begin
          // A zero divisor always yields an all-ones quotient, whatever the signs
          if (is_div_op) begin
            lo_q <= (neg_lo && !div_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi_q <= neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi_q, lo_q} <= neg_lo ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy = (state != IDLE);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.Out  = (bus.Op == OP_MFHI) ? hi_q :
                    (bus.Op == OP_MFLO) ? lo_q : '0;
endmodule
